// File: rtl/serial_signed_divide_by_power_of_2.sv
// Multi-cycle signed divide by 2^k: one arithmetic shift per clock, valid/ready on both sides.
// Define SERIAL_DIV_ROUND_TO_ZERO_EN for truncating (C-style) division; otherwise floor (a >>> k).
module serial_signed_divide_by_power_of_2 #(
   parameter int N   = 8,
   parameter int SHW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           up_valid,
   output logic           up_ready,
   input  logic [N-1:0]   up_a,
   input  logic [SHW-1:0] up_k,
   output logic           down_valid,
   input  logic           down_ready,
   output logic [N-1:0]   down_q
);

   localparam int CW = $clog2(N + 1);
   localparam int KW = (SHW > CW) ? SHW : CW;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  work_q, work_d;
   logic [N-1:0]  q_q, q_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  shifted;
   logic [N-1:0]  q_final;
   logic [KW-1:0] k_ext;

`ifdef SERIAL_DIV_ROUND_TO_ZERO_EN
   logic sticky_q, sticky_d;
   logic sign_q, sign_d;
`endif

   assign shifted = {work_q[N-1], work_q[N-1:1]};
   assign k_ext   = KW'(up_k);

`ifdef SERIAL_DIV_ROUND_TO_ZERO_EN
   // A negative dividend that lost any 1 bits is bumped toward zero; cannot overflow.
   assign q_final = shifted + {{(N-1){1'b0}}, sign_q & (sticky_q | work_q[0])};
`else
   assign q_final = shifted;
`endif

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_DIV_ROUND_TO_ZERO_EN
      sticky_d = sticky_q;
      sign_d   = sign_q;
`endif
      case (state_q)
         IDLE: begin
            if (up_valid) begin
               work_d = up_a;
`ifdef SERIAL_DIV_ROUND_TO_ZERO_EN
               sticky_d = 1'b0;
               sign_d   = up_a[N-1];
`endif
               if (up_k == '0) begin
                  q_d     = up_a;
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d   = (k_ext >= KW'(N)) ? CW'(N) : CW'(up_k);
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            work_d = shifted;
`ifdef SERIAL_DIV_ROUND_TO_ZERO_EN
            sticky_d = sticky_q | work_q[0];
`endif
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               q_d     = q_final;
               state_d = DONE;
            end
         end
         DONE: begin
            if (down_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         work_q  <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
`ifdef SERIAL_DIV_ROUND_TO_ZERO_EN
         sticky_q <= 1'b0;
         sign_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_DIV_ROUND_TO_ZERO_EN
         sticky_q <= sticky_d;
         sign_q   <= sign_d;
`endif
      end
   end

   assign up_ready   = (state_q == IDLE);
   assign down_valid = (state_q == DONE);
   assign down_q     = q_q;

endmodule

// File: tb/tb_serial_signed_divide_by_power_of_2.sv
// Bench for serial_signed_divide_by_power_of_2 (N=8, SHW=4): directed table, corner sequences, random vs model.
module tb_serial_signed_divide_by_power_of_2;

   localparam int N   = 8;
   localparam int SHW = 4;
`ifdef SERIAL_DIV_ROUND_TO_ZERO_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           up_valid = 1'b0;
   logic           up_ready;
   logic [N-1:0]   up_a = '0;
   logic [SHW-1:0] up_k = '0;
   logic           down_valid;
   logic           down_ready = 1'b0;
   logic [N-1:0]   down_q;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_signed_divide_by_power_of_2 #(.N(N), .SHW(SHW)) dut (
      .clk(clk), .rst_n(rst_n),
      .up_valid(up_valid), .up_ready(up_ready), .up_a(up_a), .up_k(up_k),
      .down_valid(down_valid), .down_ready(down_ready), .down_q(down_q)
   );

   typedef struct {
      logic [7:0] a;
      logic [3:0] k;
      logic [7:0] q_floor;
      logic [7:0] q_trunc;
      int         stall;
   } vec_t;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Reference: signed integer division by 2^min(k,N); floor adjusts truncation down for inexact negatives.
   function automatic logic [7:0] model(input logic [7:0] a, input logic [3:0] k);
      longint sa = longint'($signed(a));
      int     kk = (int'(k) > N) ? N : int'(k);
      longint d  = longint'(1) << kk;
      longint t  = sa / d;
      if (!RND && sa < 0 && (sa % d) != 0) t = t - 1;
      return 8'(t);
   endfunction

   task automatic run_txn(input string name, input logic [7:0] a, input logic [3:0] k,
                          input logic [7:0] exp, input int stall);
      int kk  = (int'(k) > N) ? N : int'(k);
      int lat = 1;
      @(negedge clk);
      chk({name, ".up_ready_idle"}, up_ready, 1);
      up_valid   = 1'b1;
      up_a       = a;
      up_k       = k;
      down_ready = (stall == 0);
      @(posedge clk);
      #1;
      up_valid = 1'b0;
      up_a     = 8'($urandom);
      up_k     = 4'($urandom);
      while (!down_valid && lat < 40) begin
         if (up_ready) chk({name, ".up_ready_busy"}, up_ready, 0);
         @(posedge clk);
         #1;
         lat++;
      end
      if (!down_valid) begin
         chk({name, ".timeout"}, 0, 1);
         down_ready = 1'b1;
         return;
      end
      chk({name, ".latency"}, lat, kk + 1);
      chk({name, ".q"}, down_q, exp);
      chk({name, ".up_ready_done"}, up_ready, 0);
      for (int i = 0; i < stall; i++) begin
         up_valid = 1'b1;
         up_a     = 8'($urandom);
         up_k     = 4'($urandom);
         @(posedge clk);
         #1;
         chk({name, ".stall_valid"}, down_valid, 1);
         chk({name, ".stall_q"}, down_q, exp);
         chk({name, ".stall_up_ready"}, up_ready, 0);
      end
      up_valid   = 1'b0;
      down_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({name, ".post_valid"}, down_valid, 0);
      chk({name, ".post_up_ready"}, up_ready, 1);
      $display("[TB] %s a=%0d k=%0d q=%0d exp=%0d lat=%0d stall=%0d",
               name, $signed(a), k, $signed(exp), $signed(exp), lat, stall);
      down_ready = 1'b0;
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{8'hF9, 4'd1,  8'hFC, 8'hFD, 0};
      vecs[1] = '{8'd100, 4'd3, 8'd12, 8'd12, 0};
      vecs[2] = '{8'h80, 4'd0,  8'h80, 8'h80, 0};
      vecs[3] = '{8'hFF, 4'd15, 8'hFF, 8'h00, 0};
      vecs[4] = '{8'h80, 4'd15, 8'hFF, 8'h00, 0};
      vecs[5] = '{8'h9C, 4'd2,  8'hE7, 8'hE7, 5};
      vecs[6] = '{8'd9,  4'd1,  8'd4,  8'd4,  0};
      vecs[7] = '{8'h80, 4'd8,  8'hFF, 8'h00, 2};

      #2;
      chk("reset.down_valid", down_valid, 0);
      chk("reset.down_q", down_q, 0);
      chk("reset.up_ready", up_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].k,
                 RND ? vecs[i].q_trunc : vecs[i].q_floor, vecs[i].stall);

      // Reset in the third SHIFT cycle discards the transaction.
      @(negedge clk);
      up_valid = 1'b1; up_a = 8'd64; up_k = 4'd6; down_ready = 1'b1;
      @(posedge clk); #1; up_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_shift.down_valid", down_valid, 0);
      chk("rst_shift.down_q", down_q, 0);
      chk("rst_shift.up_ready", up_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (down_valid) chk("rst_shift.no_stale_valid", down_valid, 0);
      end
      run_txn("rst_shift.next", 8'd64, 4'd6, 8'd1, 0);

      // Reset while holding a result in DONE clears the output register.
      @(negedge clk);
      up_valid = 1'b1; up_a = 8'h9C; up_k = 4'd2; down_ready = 1'b0;
      @(posedge clk); #1; up_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("rst_done.valid_before", down_valid, 1);
      chk("rst_done.q_before", down_q, 8'hE7);
      rst_n = 1'b0;
      #1;
      chk("rst_done.down_valid", down_valid, 0);
      chk("rst_done.down_q", down_q, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("rst_done.up_ready", up_ready, 1);

      for (int i = 0; i < 40; i++) begin
         logic [7:0] ra;
         logic [3:0] rk;
         ra = 8'($urandom);
         rk = 4'($urandom_range(0, 15));
         run_txn($sformatf("rand%0d", i), ra, rk, model(ra, rk), int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_signed_divide_by_power_of_2.md
# serial_signed_divide_by_power_of_2

Multi-cycle signed divider by a run-time power of two. Accepts a signed N-bit dividend and a shift amount over a valid/ready handshake. Shifts the dividend arithmetically one bit per clock and returns the quotient downstream over a second valid/ready handshake. Sits directly upstream of consumers that expect C-style signed division by 2^k. It is the sequential, variable-shift counterpart of the fixed-S arithmetic right shifters in this section.

## Interface
Parameters:
- `N`, default 8: dividend and quotient width, two's complement; N >= 2.
- `SHW`, default 4: width of the shift-amount port.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `up_valid`  in  1  upstream offers `up_a` and `up_k`.
- `up_ready`  out  1  block can accept; equals (state == IDLE).
- `up_a`  in  N  signed dividend.
- `up_k`  in  SHW  unsigned shift amount k (divisor 2^k).
- `down_valid`  out  1  quotient available.
- `down_ready`  in  1  downstream accepts.
- `down_q`  out  N  signed quotient.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT on `up_valid && up_ready` when k != 0. IDLE → DONE when k == 0.
  - On acceptance, load the work register with `up_a`.
  - Load the counter with min(k, N); values k >= N saturate to N.
  - Clear the sticky bit.
  - Capture the sign of `up_a`.
- SHIFT: each cycle:
  - work <= {work[N-1], work[N-1:1]}.
  - sticky <= sticky | work[0].
  - Decrement the counter.
  - When the counter reaches 1, go to DONE. The final quotient is written to `down_q` on that same edge.
- DONE: `down_valid` = 1, and `down_q` holds a stable value.
  - On `down_valid && down_ready`, go to IDLE.
  - `up_ready` rises on the following cycle. No overlap of transactions.
- Quotient, without rounding: floor(a / 2^k), i.e. the plain arithmetic shift.
- Quotient, with rounding: trunc(a / 2^k). The result is incremented by 1 when the sign is 1 and sticky is 1; the increment is N-bit and cannot overflow.
- k >= N:
  - Floor result: all sign bits (0 or −1).
  - Rounded result: 0 for every a, including −2^(N−1).
- k == 0: `down_q` = `up_a` unchanged.
- `up_a` and `up_k` are sampled only on the accepting edge. Later changes are ignored.
- Upstream signals are ignored outside IDLE.

## Timing
- Reset (`rst_n` low, asynchronous, at any time including mid-SHIFT or in DONE):
  - state = IDLE.
  - `down_valid` = 0, `down_q` = 0.
  - Counter, work register and sticky bit = 0.
  - `up_ready` = 1 after reset.
  - An in-flight transaction is discarded.
- Latency: `down_valid` is high min(k,N)+1 cycles after the accepting edge. For k = 0 it is high the cycle after acceptance.
- Throughput: one transaction per min(k,N) + 2 cycles minimum, with `down_ready` tied high.
- `down_valid` stays high and `down_q` stays stable until the handshake, for any length of backpressure.
- `down_valid` never drops without a handshake (except on reset).

## Configuration
- `SERIAL_DIV_ROUND_TO_ZERO_EN` defined: the sticky/sign correction is compiled in. Quotient = trunc(a / 2^k), matching signed C/SystemVerilog `/`.
- Not defined: sticky logic is absent. Quotient = floor(a / 2^k), identical to `a >>> k`.
- Latency and handshake are identical in both builds.

## Test plan
- N=8, a=8'hF9 (−7), k=1, down_ready=1 → `down_valid` at cycle 2. `down_q` = 8'hFC (−4) without the macro, 8'hFD (−3) with it.
- a=100, k=3 → `down_q` = 12 in both builds. `down_valid` at cycle 4; `up_ready` = 0 during cycles 1–4 and 1 at cycle 5.
- a=8'h80 (−128), k=0 → `down_q` = 8'h80 at cycle 1, with no SHIFT cycles.
- a=8'hFF (−1), k=15 (saturates to 8) → `down_valid` at cycle 9. `down_q` = 8'hFF without the macro, 8'h00 with it. Repeat with a=8'h80: 8'hFF / 8'h00.
- a=−100, k=2, down_ready held low 5 cycles after `down_valid` rises → `down_q` is stable through the stall (−25 in both builds), `up_valid` pulses are ignored, and `up_ready` = 0. After the handshake, the next transaction (a=9, k=1) yields 4.
- Assert `rst_n` low mid-SHIFT (a=64, k=6, third shift cycle) → `down_valid` = 0, `down_q` = 0 immediately, `up_ready` = 1 after release. A new transaction (a=64, k=6) yields 1 at latency 7.
